// File: rtl/naxi_slave_responder.sv
// naxi_slave_responder: memory-backed slave on the Naxi creq/dreq/rreq interface.
// One command is in flight at a time. Reads stream rows out of a small flop
// array, writes absorb dreq beats into it, and every command ends in response
// beats on rreq.
// Optional build macro NAXI_SLV_ERRCHK_EN: illegal command types get an error
// response, and write beats whose id does not match the command are dropped
// and flagged in the write ack. Without it, the type is decoded by bit 0 only
// and every write beat is stored.
module naxi_slave_responder #(
    parameter int NXADDRWIDTH = 31,
    parameter int NXDATAWIDTH = 256,
    parameter int NXIDWIDTH   = 4,
    parameter int NXTYPEWIDTH = 3,
    parameter int NXSIZEWIDTH = 8,
    parameter int NXATTRWIDTH = 3,
    parameter int NUMROWS     = 16,
    parameter int BITROWS     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   creq_valid,
    input  logic [NXTYPEWIDTH-1:0] creq_type,
    input  logic [NXATTRWIDTH-1:0] creq_attr,
    input  logic [NXSIZEWIDTH-1:0] creq_size,
    input  logic [NXIDWIDTH-1:0]   creq_id,
    input  logic [NXADDRWIDTH-1:0] creq_addr,
    output logic                   creq_rdstall,
    output logic                   creq_wrstall,
    input  logic                   dreq_valid,
    input  logic [NXIDWIDTH-1:0]   dreq_id,
    input  logic [NXDATAWIDTH-1:0] dreq_data,
    input  logic [NXATTRWIDTH-1:0] dreq_attr,
    output logic                   dreq_stall,
    output logic                   rreq_valid,
    output logic [NXIDWIDTH-1:0]   rreq_id,
    output logic [NXDATAWIDTH-1:0] rreq_data,
    output logic [NXATTRWIDTH-1:0] rreq_attr,
    input  logic                   rreq_stall
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRDATA  = 3'd1;
    localparam logic [2:0] WRACK   = 3'd2;
    localparam logic [2:0] RDRESP  = 3'd3;
    localparam logic [2:0] ERRRESP = 3'd4;

    logic [2:0]             state;
    logic [NXIDWIDTH-1:0]   cmd_id;
    logic [BITROWS-1:0]     row;
    logic [NXSIZEWIDTH-1:0] size;
    logic [NXSIZEWIDTH:0]   count;
    logic                   err_flag;
    logic [NXDATAWIDTH-1:0] mem [NUMROWS];

    logic cmd_accept;
    logic beat_accept;
    logic resp_accept;
    logic last_beat;
    logic beat_match;
    logic err_bit;
    logic [2:0] next_cmd_state;

    // Attribute bits, the upper command-address bits and (in the default build)
    // the write-beat id carry no meaning for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{creq_attr, dreq_attr, creq_addr, creq_type, dreq_id};

    assign creq_rdstall = (state != IDLE);
    assign creq_wrstall = (state != IDLE);
    assign dreq_stall   = (state != WRDATA);
    assign rreq_valid   = (state == RDRESP) || (state == WRACK) || (state == ERRRESP);

    assign cmd_accept  = creq_valid && (state == IDLE);
    assign beat_accept = dreq_valid && (state == WRDATA);
    assign resp_accept = rreq_valid && !rreq_stall;
    assign last_beat   = (count == {1'b0, size});

`ifdef NAXI_SLV_ERRCHK_EN
    assign beat_match = (dreq_id == cmd_id);
    assign err_bit    = err_flag;
    assign next_cmd_state = (creq_type == NXTYPEWIDTH'(0)) ? RDRESP :
                            (creq_type == NXTYPEWIDTH'(1)) ? WRDATA : ERRRESP;
`else
    assign beat_match = 1'b1;
    assign err_bit    = 1'b0;
    assign next_cmd_state = creq_type[0] ? WRDATA : RDRESP;
`endif

    // Response beat contents are derived purely from state, so they stay frozen under rreq_stall.
    always_comb begin
        rreq_id   = '0;
        rreq_data = '0;
        rreq_attr = '0;
        case (state)
            RDRESP: begin
                rreq_id      = cmd_id;
                rreq_data    = mem[row];
                rreq_attr[2] = last_beat;
            end
            WRACK: begin
                rreq_id      = cmd_id;
                rreq_attr[0] = 1'b1;
                rreq_attr[1] = err_bit;
                rreq_attr[2] = 1'b1;
            end
            ERRRESP: begin
                rreq_id      = cmd_id;
                rreq_attr[1] = 1'b1;
                rreq_attr[2] = 1'b1;
            end
            default: ;
        endcase
    end

    // Command sequencing: latch the command, walk rows/beats, return to IDLE after the final response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmd_id   <= '0;
            row      <= '0;
            size     <= '0;
            count    <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        cmd_id <= creq_id;
                        row    <= creq_addr[BITROWS-1:0];
                        size   <= creq_size;
                        count  <= '0;
                        state  <= next_cmd_state;
                    end
                end
                WRDATA: begin
                    if (beat_accept) begin
                        row   <= row + 1'b1;
                        count <= count + 1'b1;
                        if (!beat_match) err_flag <= 1'b1;
                        if (last_beat) state <= WRACK;
                    end
                end
                WRACK: begin
                    if (resp_accept) begin
                        err_flag <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RDRESP: begin
                    if (resp_accept) begin
                        row   <= row + 1'b1;
                        count <= count + 1'b1;
                        if (last_beat) state <= IDLE;
                    end
                end
                ERRRESP: begin
                    if (resp_accept) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Backing store: written on the dreq accept edge so a later read sees the new data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUMROWS; i++) mem[i] <= '0;
        end else if (beat_accept && beat_match) begin
            mem[row] <= dreq_data;
        end
    end

endmodule
